// File: rtl/fifo_pkg.sv
// Shared definitions for the virtual-channel FIFO arbiter slice.
package fifo_pkg;

    localparam int unsigned BUS_SIZE = 5;
    localparam int unsigned NUM_IN   = 4;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first requester after last_grant, scanning cyclically.
module rr_pick4
    import fifo_pkg::*;
(
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  last_grant_i,
    output logic              any_req_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the nearest requester after last_grant wins.
    always_comb begin
        any_req_o = |req_i;
        idx_o     = IDX_W'(last_grant_i + IDX_W'(1));
        cand      = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = IDX_W'(last_grant_i + IDX_W'(k));
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin drain of four VC FIFOs into one downstream FIFO with pause/continua flow control.
module rr_fifo_arbiter #(
    parameter int unsigned BUS_SIZE = fifo_pkg::BUS_SIZE
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [fifo_pkg::NUM_IN-1:0]          empty_in,
    input  logic [fifo_pkg::NUM_IN*BUS_SIZE-1:0] data_in,
    input  logic [fifo_pkg::NUM_IN-1:0]          valid_in,
    input  logic                                 pause,
    input  logic                                 continua,
    output logic [fifo_pkg::NUM_IN-1:0]          pop,
    output logic                                 push,
    output logic [BUS_SIZE-1:0]                  data_out,
    output logic                                 valid_out,
    output logic [fifo_pkg::IDX_W-1:0]           grant_id,
    output logic                                 idle
);

    import fifo_pkg::*;

    arb_state_t       state_q;
    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] grant_id_q;
    logic             inflight_q;

    logic [NUM_IN-1:0] req;
    logic              any_req;
    logic [IDX_W-1:0]  pick_idx;
    logic              issue;

    assign req = ~empty_in;

    rr_pick4 u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .any_req_o    (any_req),
        .idx_o        (pick_idx)
    );

    // Pop is issued straight from registered state so the upstream read lands next cycle.
    always_comb begin
        pop   = '0;
        issue = reset & (state_q == RUN) & any_req;
        if (issue) begin
            pop[pick_idx] = 1'b1;
        end
    end

    // Grant pointer, push pipeline and RUN/HOLD hysteresis; pause dominates continua.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RUN;
            last_grant_q <= IDX_W'(NUM_IN - 1);
            grant_id_q   <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            grant_id_q <= pick_idx;
            if (issue) begin
                last_grant_q <= pick_idx;
            end
            if (pause) begin
                state_q <= HOLD;
            end else if ((state_q == HOLD) && continua) begin
                state_q <= RUN;
            end
        end
    end

    // Forward the word returned by the granted FIFO; outputs are quiet when nothing is pushed.
    always_comb begin
        push      = inflight_q;
        grant_id  = grant_id_q;
        data_out  = '0;
        valid_out = 1'b0;
        if (inflight_q) begin
            data_out  = data_in[32'(grant_id_q) * BUS_SIZE +: BUS_SIZE];
            valid_out = valid_in[grant_id_q];
        end
        idle = (&empty_in) & ~inflight_q;
    end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed bench for rr_fifo_arbiter: vector table plus model-driven multi-cycle sequences.
module tb_rr_fifo_arbiter;

    localparam int unsigned BW       = 5;
    localparam int unsigned UMBRAL_A = 6;
    localparam int unsigned UMBRAL_B = 2;
    localparam int unsigned DS_DEPTH = 8;
    localparam int unsigned NVEC     = 27;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty_in;
    logic [19:0] data_in;
    logic [3:0]  valid_in;
    logic        pause;
    logic        continua;
    logic [3:0]  pop;
    logic        push;
    logic [4:0]  data_out;
    logic        valid_out;
    logic [1:0]  grant_id;
    logic        idle;

    always #5 clk = ~clk;

    rr_fifo_arbiter #(.BUS_SIZE(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty_in  (empty_in),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .pause     (pause),
        .continua  (continua),
        .pop       (pop),
        .push      (push),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant_id  (grant_id),
        .idle      (idle)
    );

    // Source selection: directly driven table inputs or behavioural FIFO models
    logic       use_model;
    logic [3:0] tbl_empty;
    logic       tbl_pause;
    logic       tbl_cont;
    logic [4:0] tbl_d [4];
    logic [3:0] tbl_valid;

    logic [4:0] mem [4][8];
    logic [3:0] wr_ptr [4];
    logic [3:0] rd_ptr [4];
    logic [4:0] m_dout [4];
    logic [3:0] m_vout;
    logic [3:0] m_empty;
    logic       m_clr;
    logic [3:0] ld_en;
    logic [4:0] ld_data [4];
    logic [4:0] ds_count;
    logic       drain;

    always_comb begin
        for (int i = 0; i < 4; i++) m_empty[i] = (wr_ptr[i] == rd_ptr[i]);
        if (use_model) begin
            empty_in = m_empty;
            data_in  = {m_dout[3], m_dout[2], m_dout[1], m_dout[0]};
            valid_in = m_vout;
            pause    = (32'(ds_count) >= UMBRAL_A);
            continua = (32'(ds_count) <= UMBRAL_B);
        end else begin
            empty_in = tbl_empty;
            data_in  = {tbl_d[3], tbl_d[2], tbl_d[1], tbl_d[0]};
            valid_in = tbl_valid;
            pause    = tbl_pause;
            continua = tbl_cont;
        end
    end

    // Upstream FIFOs with one-cycle read latency and a downstream occupancy counter
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_clr) begin
                wr_ptr[i] <= 4'd0;
                rd_ptr[i] <= 4'd0;
                m_vout[i] <= 1'b0;
                m_dout[i] <= 5'd0;
            end else begin
                if (ld_en[i]) begin
                    mem[i][wr_ptr[i][2:0]] <= ld_data[i];
                    wr_ptr[i] <= wr_ptr[i] + 4'd1;
                end
                if (pop[i] && !m_empty[i]) begin
                    m_dout[i] <= mem[i][rd_ptr[i][2:0]];
                    rd_ptr[i] <= rd_ptr[i] + 4'd1;
                    m_vout[i] <= 1'b1;
                end else begin
                    m_vout[i] <= 1'b0;
                end
            end
        end
        if (m_clr) ds_count <= 5'd0;
        else       ds_count <= ds_count + 5'(push) - 5'(drain && (ds_count != 5'd0));
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] empty;
        logic       pause;
        logic       cont;
        logic [3:0] pop;
        logic       push;
        logic [1:0] gid;
        logic       idle;
    } vec_t;

    vec_t tbl [NVEC];

    // Logs filled by run_model
    int         pop_cnt [4];
    logic [1:0] log_gid [$];
    logic [4:0] log_dat [$];
    int         hold_bad, onehot_bad, extra_max, ds_max, vbad;
    logic       pause_seen;

    task automatic load_model(input int n0, input int n1, input int n2, input int n3);
        int n [4];
        n = '{n0, n1, n2, n3};
        @(negedge clk);
        reset = 1'b0; use_model = 1'b1; m_clr = 1'b1; ld_en = 4'd0; drain = 1'b0;
        @(negedge clk);
        m_clr = 1'b0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                ld_en[i]   = (j < n[i]);
                ld_data[i] = 5'(i * 8 + j);
            end
            @(negedge clk);
        end
        ld_en = 4'd0;
        reset = 1'b1;
    endtask

    task automatic run_model(input int ncyc, input int drain_start);
        logic hold_exp;
        int   extra;
        hold_exp = 1'b0; extra = 0;
        hold_bad = 0; onehot_bad = 0; extra_max = 0; ds_max = 0; vbad = 0; pause_seen = 1'b0;
        for (int i = 0; i < 4; i++) pop_cnt[i] = 0;
        log_gid.delete();
        log_dat.delete();
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if ((pop != 4'd0) && !$onehot(pop)) onehot_bad++;
            if (hold_exp && (pop != 4'd0)) hold_bad++;
            for (int i = 0; i < 4; i++) if (pop[i]) pop_cnt[i]++;
            if (push) begin
                log_gid.push_back(grant_id);
                log_dat.push_back(data_out);
                if (!valid_out) vbad++;
            end
            if (hold_exp) begin
                if (push) extra++;
                if (extra > extra_max) extra_max = extra;
            end else begin
                extra = 0;
            end
            if (int'(ds_count) > ds_max) ds_max = int'(ds_count);
            if (pause) begin
                hold_exp   = 1'b1;
                pause_seen = 1'b1;
            end else if (hold_exp && continua) begin
                hold_exp = 1'b0;
            end
            drain = (c >= drain_start);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [4:0] exp_d;
        logic       exp_v;
        logic [1:0] eg [4];
        logic [4:0] ed [4];
        int         n;

        tbl_d     = '{5'h03, 5'h0C, 5'h15, 5'h1E};
        tbl_valid = 4'b1011;
        reset = 1'b0; use_model = 1'b0; m_clr = 1'b1; ld_en = 4'd0; drain = 1'b0;
        tbl_empty = 4'b0000; tbl_pause = 1'b0; tbl_cont = 1'b0;
        for (int i = 0; i < 4; i++) ld_data[i] = 5'd0;

        //            rst   empty    p     c     pop      push  gid   idle
        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0};
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0};
        tbl[7]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd1, 1'b0};
        tbl[8]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd3, 1'b0};
        tbl[9]  = '{1'b1, 4'b0111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{1'b1, 4'b0111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[11] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};
        tbl[12] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
        tbl[15] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
        tbl[19] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b0};
        tbl[20] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
        tbl[21] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[22] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0};
        tbl[23] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};
        tbl[24] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
        tbl[25] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
        tbl[26] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1};

        repeat (2) @(posedge clk);

        // Reset, rotation, skipping, hold/hysteresis and mid-transfer reset
        for (int k = 0; k < int'(NVEC); k++) begin
            @(negedge clk);
            reset     = tbl[k].rst;
            tbl_empty = tbl[k].empty;
            tbl_pause = tbl[k].pause;
            tbl_cont  = tbl[k].cont;
            #1;
            exp_d = tbl[k].push ? tbl_d[tbl[k].gid] : 5'd0;
            exp_v = tbl[k].push ? tbl_valid[tbl[k].gid] : 1'b0;
            chk($sformatf("vec%0d pop", k), 32'(pop), 32'(tbl[k].pop));
            chk($sformatf("vec%0d push", k), 32'(push), 32'(tbl[k].push));
            if (tbl[k].push) chk($sformatf("vec%0d grant_id", k), 32'(grant_id), 32'(tbl[k].gid));
            chk($sformatf("vec%0d data_out", k), 32'(data_out), 32'(exp_d));
            chk($sformatf("vec%0d valid_out", k), 32'(valid_out), 32'(exp_v));
            chk($sformatf("vec%0d idle", k), 32'(idle), 32'(tbl[k].idle));
        end

        // Skip empty FIFOs: FIFO1 has 3 words, FIFO3 has 1
        load_model(0, 3, 0, 1);
        run_model(10, 0);
        eg = '{2'd1, 2'd3, 2'd1, 2'd1};
        ed = '{5'd8, 5'd24, 5'd9, 5'd10};
        chk("skip push count", 32'(log_gid.size()), 32'd4);
        n = (log_gid.size() < 4) ? log_gid.size() : 4;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("skip gid%0d", k), 32'(log_gid[k]), 32'(eg[k]));
            chk($sformatf("skip data%0d", k), 32'(log_dat[k]), 32'(ed[k]));
        end
        chk("skip pops fifo0", 32'(pop_cnt[0]), 32'd0);
        chk("skip pops fifo1", 32'(pop_cnt[1]), 32'd3);
        chk("skip pops fifo3", 32'(pop_cnt[3]), 32'd1);
        chk("skip idle", 32'(idle), 32'd1);
        chk("skip valid", 32'(vbad), 32'd0);

        // Single-entry FIFO2 is popped exactly once
        load_model(0, 0, 1, 0);
        run_model(8, 0);
        chk("single pops fifo2", 32'(pop_cnt[2]), 32'd1);
        chk("single pops others", 32'(pop_cnt[0] + pop_cnt[1] + pop_cnt[3]), 32'd0);
        chk("single push count", 32'(log_gid.size()), 32'd1);
        if (log_gid.size() > 0) begin
            chk("single gid", 32'(log_gid[0]), 32'd2);
            chk("single data", 32'(log_dat[0]), 32'd16);
        end

        // Downstream stalled until well after pause, then drained
        load_model(4, 4, 4, 4);
        run_model(80, 25);
        chk("flow pause seen", 32'(pause_seen), 32'd1);
        chk("flow pop in hold", 32'(hold_bad), 32'd0);
        chk("flow extra push ok", 32'(extra_max <= 1), 32'd1);
        chk("flow no overflow", 32'(ds_max <= int'(DS_DEPTH)), 32'd1);
        chk("flow onehot", 32'(onehot_bad), 32'd0);
        chk("flow push count", 32'(log_gid.size()), 32'd16);
        n = (log_gid.size() < 16) ? log_gid.size() : 16;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("flow gid%0d", k), 32'(log_gid[k]), 32'(k % 4));
            chk($sformatf("flow data%0d", k), 32'(log_dat[k]), 32'((k % 4) * 8 + k / 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_fifo_arbiter.md
Name: rr_fifo_arbiter

Overview:
- Downstream consumer of four FIFO_mod virtual-channel FIFOs.
- Selects one non-empty FIFO per cycle by round-robin and issues its pop.
- Forwards the returned word and valid bit as a push into one downstream FIFO_mod.
- Obeys the downstream pause/continua hysteresis; this is the flow-control stage between the VC FIFOs and the next FIFO.

Parameters:
- BUS_SIZE, 5, data width; equals the FIFO_mod BUS_SIZE.
- NUM_IN, 4, number of upstream FIFOs; fixed at 4 for this revision.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset; 0 sampled on a clk edge resets the block.
- empty_in  in  4  empty flag of each upstream FIFO; bit i belongs to FIFO i.
- data_in  in  4*BUS_SIZE  upstream data_out buses; FIFO i occupies bits [i*BUS_SIZE +: BUS_SIZE].
- valid_in  in  4  upstream valid_out bits.
- pause  in  1  downstream almost_full.
- continua  in  1  downstream almost_empty.
- pop  out  4  one-hot pop to the upstream FIFOs; all zero when no grant.
- push  out  1  push to the downstream FIFO.
- data_out  out  BUS_SIZE  data to the downstream FIFO.
- valid_out  out  1  valid bit to the downstream FIFO.
- grant_id  out  2  index of the FIFO that produced the current push.
- idle  out  1  all upstream FIFOs empty and nothing in flight.

Behaviour:
- Reset (reset==0 at an edge):
  - state=RUN.
  - last_grant=3, so FIFO 0 has first priority.
  - push=0, grant_id=0, inflight=0.
  - The pop output is forced to 0 while reset is low.
- Upstream read latency is 1 cycle: data and valid are valid in the cycle after pop.
- Pop issue (combinational from registered state and inputs):
  - pop is asserted only when state==RUN and at least one empty_in bit is 0.
  - Granted index = first i with empty_in[i]==0, scanning cyclically from last_grant+1.
  - pop is one-hot on the granted index.
  - last_grant updates to the granted index at the same edge.
- Back-to-back pops, including repeated pops of the same FIFO, are allowed.
  - FIFO_mod empty updates one edge after pop, so a single-entry FIFO is never over-popped.
- Push stage (registered):
  - At each edge: inflight<=|pop and grant_id<=granted index.
  - push = inflight.
  - data_out = data_in slice selected by grant_id, muxed combinationally from the upstream registered outputs.
  - valid_out = valid_in[grant_id].
  - When push==0, data_out and valid_out are 0.
- State machine (evaluated at each edge, with priority):
  - RUN -> HOLD when pause==1.
  - HOLD -> RUN when continua==1 and pause==0.
  - Otherwise the state holds.
  - In HOLD, no new pops are issued.
  - The single pop already in flight when pause rises still completes its push. The downstream umbralA must leave at least 1 entry of headroom.
- Simultaneous pause and continua: pause wins, and the state goes to or stays in HOLD.
- Round-robin wrap: after index 3 the scan restarts at 0.
- Empty FIFOs are skipped with no idle cycle.
- If only one FIFO is non-empty, it receives every grant.
- idle = (&empty_in) & ~inflight.
- Reset mid-transfer: a pending in-flight push is discarded (push=0 the next cycle). The upstream word is lost, which is acceptable because the whole design resets together.

Decomposition:
- Shared package, fifo_pkg:
  - BUS_SIZE default.
  - NUM_IN.
  - State encodings RUN=1'b0, HOLD=1'b1.
- One sub-module, rr_pick4:
  - Purely combinational.
  - Inputs: 4-bit request vector (~empty_in) and 2-bit last_grant.
  - Outputs: any_req and a 2-bit index.
  - Instantiated once.

Test Plan:
1. Reset and priority start: hold reset low 2 cycles, then release with all FIFOs holding 2 words. Required: push=0 and pop=0 during reset. After release, pop order is 0,1,2,3,0,1,2,3 on consecutive cycles, with push and grant_id following one cycle later.
2. Skip empty FIFOs: FIFO 1 holds 3 words, FIFO 3 holds 1 word, FIFOs 0 and 2 are empty. Required grants: 1,3,1,1, then idle=1. The pushed data matches each FIFO's contents in order.
3. Pause/continua hysteresis: with umbralA=6 and umbralB=2, fill the upstream FIFOs and stall downstream pops. Required:
   - Pops stop in the cycle after pause rises.
   - At most 1 extra push follows.
   - The downstream FIFO never reaches fifo_error.
   - Pops resume only once continua=1.
4. Simultaneous pause and continua forced high: required state HOLD, with no pops until pause drops.
5. Single-entry back-to-back: FIFO 2 holds 1 word, all others empty. Required: exactly one pop[2] pulse, one push with grant_id=2, and no second pop.
6. Reset mid-transfer: assert reset in the cycle a pop is issued. Required: push=0 in the following cycle, and after release arbitration restarts at FIFO 0.
